lin_header_tx: RTL
==================

// Module: lin_header_tx
// PURPOSE
//  Master-side LIN header transmitter. On a start request it serialises a complete frame
//  header onto the bus TX line: break, break delimiter, sync byte 0x55 and protected ID.
//  The protected ID is {P1,P0,ID[5:0]}. Sits in the APB LIN top beside the slave PID
//  lookup; it produces exactly the PID stream that the slave lookup decodes.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per LIN bit time (>=2)
//  BREAK_BITS    13  dominant bits in the break field (>=13)
//  DELIM_BITS     1  recessive bits in the break delimiter (>=1)
// PORTS
//  clk      in   1  system clock, rising edge
//  rst_n    in   1  asynchronous active-low reset
//  start    in   1  header request, sampled when busy==0
//  id       in   6  frame identifier, captured with start
//  tx       out  1  LIN TX line, 1=recessive, 0=dominant
//  busy     out  1  header in progress
//  done     out  1  one-cycle pulse, header complete
//  pid_out  out  8  protected ID of the last accepted request
// BEHAVIOUR
//  - Reset (async assert, sync release): tx=1, busy=0, done=0, pid_out=8'h00,
//    FSM=IDLE, all counters 0. Reset mid-header: tx returns to 1 immediately; nothing resumes.
//  - Parity: P0=ID0^ID1^ID2^ID4; P1=~(ID1^ID3^ID4^ID5). pid_out is registered at acceptance.
//  - Accept: start=1 && busy==0 at edge T. id and pid_out are latched. busy=1 and tx=0 from T+1.
//    The bit timer restarts at 0, so each bit lasts exactly CLKS_PER_BIT clocks.
//  - FSM: IDLE -> BREAK (BREAK_BITS bits of tx=0) -> DELIM (DELIM_BITS bits of tx=1)
//    -> SYNC (frame 0x55) -> PID (frame pid_out) -> IDLE.
//  - Byte frame: 10 bits. Start bit 0, then 8 data bits LSB first, then stop bit 1.
//    There is no inter-byte space.
//  - Total header = BREAK_BITS+DELIM_BITS+20 bit times (34 at default), measured from T+1.
//  - The last PID stop bit ends at clk edge E. At E: done=1 for one cycle, busy=0, tx=1.
//  - start while busy==1 is ignored, with no queueing. start in the done cycle is accepted
//    as a new header (back-to-back), because busy==0 in that cycle.
//  - id changes while busy have no effect. tx changes only at bit boundaries, and is
//    glitch-free because it is driven from a register.
//  - Counters: bit timer is $clog2(CLKS_PER_BIT) wide and wraps at CLKS_PER_BIT-1.
//    Bit index is 5 bits and covers max(BREAK_BITS,10).
// STRUCTURE
//  - lin_pkg: LIN_SYNC_BYTE=8'h55, FSM state encodings (IDLE,BREAK,DELIM,SYNC,PID),
//    function lin_pid(id6)->pid8.
//  - Sub-module lin_bit_timer: counts CLKS_PER_BIT and emits bit_end. It is cleared on accept.
//  - The top holds the FSM, the bit index counter and the shift register.
// TESTING
//  1 Reset with no start -> tx=1, busy=0, done=0, pid_out=00 held for 100 bit times.
//  2 id=6'h3C -> pid_out=8'h3C. tx shows 13b of 0, 1b of 1, 0+0x55 LSB-first+1,
//    0+0x3C LSB-first+1. done occurs 34*CLKS_PER_BIT clocks after T+1.
//  3 id=6'h3D -> 8'h7D; id=6'h23 -> 8'hA3; id=6'h20 -> 8'h20.
//    Each case is checked by sampling tx at mid-bit.
//  4 Pulse start again with id=6'h30 during SYNC -> ignored. The PID byte sent still
//    matches the first id, and exactly one done pulse occurs.
//  5 Hold start=1 continuously with id=6'h3C -> headers run back-to-back.
//    The next break starts the cycle after done, and there is no extra recessive bit.
//  6 Assert rst_n=0 at bit 5 of BREAK -> tx=1 and busy=0 asynchronously.
//    After release, a new start yields a full, correct header.

Source files
------------

// File: rtl/lin_pkg.sv
// rtl/lin_pkg.sv - shared LIN constants, header FSM states and PID parity helper
package lin_pkg;

    localparam logic [7:0] LIN_SYNC_BYTE = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_DELIM,
        ST_SYNC,
        ST_PID
    } lin_state_t;

    // Protected ID = {P1, P0, ID[5:0]}
    function automatic logic [7:0] lin_pid(input logic [5:0] id6);
        logic p0;
        logic p1;
        p0 = id6[0] ^ id6[1] ^ id6[2] ^ id6[4];
        p1 = ~(id6[1] ^ id6[3] ^ id6[4] ^ id6[5]);
        return {p1, p0, id6};
    endfunction

endpackage

// File: rtl/lin_bit_timer.sv
// rtl/lin_bit_timer.sv - bit-time divider emitting bit_end on the last clk of each bit
module lin_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic bit_end
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;

    assign bit_end = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_end ? '0 : cnt + TW'(1);
        end
    end

endmodule

// File: rtl/lin_header_tx.sv
// rtl/lin_header_tx.sv - master LIN header serialiser: break, delimiter, sync 0x55, protected ID
module lin_header_tx
    import lin_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int BREAK_BITS   = 13,
    parameter int DELIM_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] id,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] pid_out
);

    localparam logic [4:0] BREAK_LAST = 5'(BREAK_BITS - 1);
    localparam logic [4:0] DELIM_LAST = 5'(DELIM_BITS - 1);
    localparam logic [4:0] FRAME_LAST = 5'd9;

    lin_state_t state, state_nxt;
    logic [4:0] idx, idx_nxt;
    logic [9:0] sh, sh_nxt;
    logic       tx_nxt, busy_nxt, done_nxt;
    logic [7:0] pid_nxt;
    logic       accept;
    logic       bit_end;

    lin_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .en     (busy),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            sh      <= '1;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            pid_out <= 8'h00;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            sh      <= sh_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            pid_out <= pid_nxt;
        end
    end

    // Byte frames live in sh as {stop, data, start}; tx always mirrors sh[0] while framing
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        sh_nxt    = sh;
        tx_nxt    = tx;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        pid_nxt   = pid_out;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    pid_nxt   = lin_pid(id);
                    state_nxt = ST_BREAK;
                    idx_nxt   = '0;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            ST_BREAK: begin
                if (bit_end) begin
                    if (idx == BREAK_LAST) begin
                        state_nxt = ST_DELIM;
                        idx_nxt   = '0;
                        tx_nxt    = 1'b1;
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            ST_DELIM: begin
                if (bit_end) begin
                    if (idx == DELIM_LAST) begin
                        state_nxt = ST_SYNC;
                        idx_nxt   = '0;
                        sh_nxt    = {1'b1, LIN_SYNC_BYTE, 1'b0};
                        tx_nxt    = 1'b0;
                    end else begin
                        idx_nxt = idx + 5'd1;
                    end
                end
            end
            ST_SYNC: begin
                if (bit_end) begin
                    if (idx == FRAME_LAST) begin
                        state_nxt = ST_PID;
                        idx_nxt   = '0;
                        sh_nxt    = {1'b1, pid_out, 1'b0};
                        tx_nxt    = 1'b0;
                    end else begin
                        idx_nxt = idx + 5'd1;
                        sh_nxt  = {1'b1, sh[9:1]};
                        tx_nxt  = sh[1];
                    end
                end
            end
            ST_PID: begin
                if (bit_end) begin
                    if (idx == FRAME_LAST) begin
                        state_nxt = ST_IDLE;
                        idx_nxt   = '0;
                        sh_nxt    = '1;
                        tx_nxt    = 1'b1;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + 5'd1;
                        sh_nxt  = {1'b1, sh[9:1]};
                        tx_nxt  = sh[1];
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
